// File: rtl/lock_client_pkg.sv
// -----------------------------------------------------------------------------
// lock_client_pkg
//   Shared type definitions for the synchronous tree arbiter: the client-side
//   phase enum used by lock_client, plus the cell and process phase enums, so
//   cells, clients and benches all agree on encodings.
//   Helper: eff_hold_len() maps a requested hold length to the number of LOCK
//   cycles actually spent (0 behaves as 1).
// -----------------------------------------------------------------------------
package lock_client_pkg;

   // Phase of a lock_client agent.
   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      REQ     = 2'd1,
      LOCK    = 2'd2,
      RELEASE = 2'd3
   } client_phase_t;

   // State of a two-input arbiter cell (which side currently holds the grant).
   typedef enum logic [1:0] {
      CELL_IDLE   = 2'd0,
      CELL_GRANT1 = 2'd1,
      CELL_GRANT2 = 2'd2
   } cell_state_t;

   // Phase of a bare client process (non-critical, trying, critical).
   typedef enum logic [1:0] {
      PROC_NONCRIT  = 2'd0,
      PROC_TRYING   = 2'd1,
      PROC_CRITICAL = 2'd2
   } proc_phase_t;

   // A zero hold length still has to occupy the lock for one cycle.
   function automatic int unsigned eff_hold_len(input int unsigned len);
      return (len == 0) ? 1 : len;
   endfunction

endpackage

// File: rtl/lock_client_if.sv
// -----------------------------------------------------------------------------
// lock_client_if
//   Bundles the job-source and leaf-cell handshake signals of one lock_client.
//   master : environment side (job source + leaf arbiter cell)
//            drives job_valid, hold_len, ack; observes the client outputs.
//   slave  : the lock_client itself.
//   Signals: job_valid, hold_len[HOLD_W], ack, req, busy, pending[PEND_W],
//            done, overflow, proto_err.
// -----------------------------------------------------------------------------
interface lock_client_if #(
   parameter int HOLD_W = 4,
   parameter int PEND_W = 3
);
   logic              job_valid;
   logic [HOLD_W-1:0] hold_len;
   logic              ack;
   logic              req;
   logic              busy;
   logic [PEND_W-1:0] pending;
   logic              done;
   logic              overflow;
   logic              proto_err;

   modport master (
      output job_valid, hold_len, ack,
      input  req, busy, pending, done, overflow, proto_err
   );

   modport slave (
      input  job_valid, hold_len, ack,
      output req, busy, pending, done, overflow, proto_err
   );
endinterface

// File: rtl/lock_client_hold_timer.sv
// -----------------------------------------------------------------------------
// hold_timer
//   Down-counter that times the critical section of a lock_client.
//   Ports:
//     clk, rst    clock, asynchronous active-high reset
//     load_i      load load_val_i (takes priority over dec_i)
//     dec_i       decrement by one (stops at 0)
//     load_val_i  value to load, HOLD_W bits
//     last_o      counter currently equals 1 (final cycle of the hold)
// -----------------------------------------------------------------------------
module hold_timer #(
   parameter int HOLD_W = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              load_i,
   input  logic              dec_i,
   input  logic [HOLD_W-1:0] load_val_i,
   output logic              last_o
);
   logic [HOLD_W-1:0] cnt_q;
   logic [HOLD_W-1:0] cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (load_i) begin
         cnt_d = load_val_i;
      end else if (dec_i && (cnt_q != '0)) begin
         cnt_d = cnt_q - 1'b1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign last_o = (cnt_q == HOLD_W'(1));
endmodule

// File: rtl/lock_client.sv
// -----------------------------------------------------------------------------
// lock_client
//   Leaf agent of the synchronous tree arbiter. Queues job pulses, requests the
//   shared resource from its level-0 cell, holds the lock for max(hold_len,1)
//   cycles, then releases and waits for ack to fall before re-arming.
//   Ports:
//     clk, rst   clock (posedge), asynchronous active-high reset
//     bus        lock_client_if.slave:
//                  job_valid in  one-cycle pulse per new job
//                  hold_len  in  lock duration (0 behaves as 1)
//                  ack       in  grant from leaf cell
//                  req       out request to leaf cell (REQ or LOCK)
//                  busy      out high during LOCK
//                  pending   out queued jobs not yet granted (saturating)
//                  done      out one-cycle pulse per completed job
//                  overflow  out sticky, a job was dropped at full
//                  proto_err out sticky protocol violation
//   Build option: LOCK_CLIENT_PROTO_CHECK_EN enables the ack protocol checker;
//   without it proto_err is tied low.
// -----------------------------------------------------------------------------
module lock_client
   import lock_client_pkg::*;
#(
   parameter int HOLD_W = 4,
   parameter int PEND_W = 3
) (
   input  logic         clk,
   input  logic         rst,
   lock_client_if.slave bus
);
   localparam logic [PEND_W-1:0] PEND_MAX = '1;

   client_phase_t     state_q;
   logic              req_q;
   logic              busy_q;
   logic              done_q;
   logic [PEND_W-1:0] pend_q;
   logic [PEND_W-1:0] pend_d;
   logic              ovf_q;
   logic              ovf_d;

   logic              grant;
   logic              start;
   logic              timer_last;
   logic [HOLD_W-1:0] timer_load_val;

   // ack only counts as a grant while we are actually requesting.
   assign grant = (state_q == REQ) && bus.ack;
   assign start = (pend_q != '0) || bus.job_valid;

   assign timer_load_val = HOLD_W'(eff_hold_len(32'(bus.hold_len)));

   hold_timer #(
      .HOLD_W (HOLD_W)
   ) u_hold_timer (
      .clk        (clk),
      .rst        (rst),
      .load_i     (grant),
      .dec_i      (state_q == LOCK),
      .load_val_i (timer_load_val),
      .last_o     (timer_last)
   );

   // Phase sequencer; req/busy/done are registered alongside the state so
   // they are clean Moore outputs (req = REQ|LOCK, busy = LOCK).
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         req_q   <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         done_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (start) begin
                  state_q <= REQ;
                  req_q   <= 1'b1;
               end
            end
            REQ: begin
               if (bus.ack) begin
                  state_q <= LOCK;
                  busy_q  <= 1'b1;
               end
            end
            LOCK: begin
               if (timer_last) begin
                  state_q <= RELEASE;
                  req_q   <= 1'b0;
                  busy_q  <= 1'b0;
               end
            end
            RELEASE: begin
               // Hold off until the leaf cell has withdrawn its grant so it
               // always sees an idle cycle before the next request.
               if (!bus.ack) begin
                  state_q <= IDLE;
                  done_q  <= 1'b1;
               end
            end
            default: begin
               state_q <= IDLE;
               req_q   <= 1'b0;
               busy_q  <= 1'b0;
            end
         endcase
      end
   end

   // Pending-job counter. A job arriving in the same cycle as a grant is
   // consumed by that grant, which also covers the pending==0 grant path.
   always_comb begin
      pend_d = pend_q;
      ovf_d  = ovf_q;
      if (grant && !bus.job_valid) begin
         if (pend_q != '0) begin
            pend_d = pend_q - 1'b1;
         end
      end else if (bus.job_valid && !grant) begin
         if (pend_q == PEND_MAX) begin
            ovf_d = 1'b1;
         end else begin
            pend_d = pend_q + 1'b1;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pend_q <= '0;
         ovf_q  <= 1'b0;
      end else begin
         pend_q <= pend_d;
         ovf_q  <= ovf_d;
      end
   end

`ifdef LOCK_CLIENT_PROTO_CHECK_EN
   // Number of preceding consecutive RELEASE cycles with ack still high.
   logic [1:0] rel_ack_cnt_q;
   logic       proto_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rel_ack_cnt_q <= 2'd0;
         proto_q       <= 1'b0;
      end else begin
         if ((state_q == RELEASE) && bus.ack) begin
            if (rel_ack_cnt_q != 2'd3) begin
               rel_ack_cnt_q <= rel_ack_cnt_q + 2'd1;
            end
         end else begin
            rel_ack_cnt_q <= 2'd0;
         end

         // Two ack-high RELEASE cycles are tolerated; a third is an error.
         if (((state_q == IDLE) && bus.ack) ||
             ((state_q == LOCK) && !bus.ack) ||
             ((state_q == RELEASE) && bus.ack && (rel_ack_cnt_q >= 2'd2))) begin
            proto_q <= 1'b1;
         end
      end
   end

   assign bus.proto_err = proto_q;
`else
   assign bus.proto_err = 1'b0;
`endif

   assign bus.req      = req_q;
   assign bus.busy     = busy_q;
   assign bus.done     = done_q;
   assign bus.pending  = pend_q;
   assign bus.overflow = ovf_q;
endmodule

// File: tb/tb_lock_client.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// tb_lock_client
//   Self-checking bench for lock_client. A negedge leaf-cell model raises ack
//   two cycles after req rises and drops it as soon as req falls. Expected
//   busy lengths are queued when a job is issued and checked on each done.
// -----------------------------------------------------------------------------
module tb_lock_client;
   localparam int HOLD_W = 4;
   localparam int PEND_W = 3;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   lock_client_if #(.HOLD_W(HOLD_W), .PEND_W(PEND_W)) bus ();

   lock_client #(.HOLD_W(HOLD_W), .PEND_W(PEND_W)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   // ---------------- leaf cell model (only driver of ack) ----------------
   bit ack_block = 1'b0;
   bit ack_force = 1'b0;
   int ack_age   = 0;

   always @(negedge clk) begin
      if (bus.req !== 1'b1) begin
         bus.ack = 1'b0;
         ack_age = 0;
      end else if (ack_force) begin
         bus.ack = 1'b1;
      end else if (ack_block) begin
         bus.ack = 1'b0;
      end else begin
         if (ack_age < 2) ack_age++;
         if (ack_age >= 2) bus.ack = 1'b1;
      end
   end

   // ---------------- checking state ----------------
   int n_checks = 0;
   int n_fail   = 0;
   int sb_q[$];
   int done_cnt = 0;
   int busy_run = 0;
   int last_len = 0;
   int req_low_run = 0;
   bit had_lock = 1'b0;
   bit prev_req = 1'b0;

   task automatic chk(input string name, input int act, input int exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   // Samples outputs 1ns after every rising edge; all checking runs here or
   // in the main sequence, both in the same process.
   task automatic tick();
      @(posedge clk);
      #1;
      if (rst) begin
         busy_run = 0;
         had_lock = 1'b0;
         req_low_run = 0;
         prev_req = 1'b0;
      end else begin
         if (bus.busy) begin
            busy_run++;
         end else if (busy_run > 0) begin
            last_len = busy_run;
            busy_run = 0;
            had_lock = 1'b1;
         end
         if (bus.done) begin
            done_cnt++;
            if (sb_q.size() == 0) begin
               chk("unexpected_done", int'(bus.done), 0);
            end else begin
               chk("busy_len", last_len, sb_q.pop_front());
            end
         end
         if (bus.req && !prev_req && had_lock) begin
            chk("req_gap_ge2", int'(req_low_run >= 2), 1);
         end
         req_low_run = bus.req ? 0 : req_low_run + 1;
         prev_req = bus.req;
      end
   endtask

   task automatic wait_done(input int target, input int budget);
      int k = 0;
      while (done_cnt < target && k < budget) begin
         tick();
         k++;
      end
      chk("done_count", done_cnt, target);
   endtask

   task automatic wait_busy(input int budget);
      int k = 0;
      while (!bus.busy && k < budget) begin
         tick();
         k++;
      end
      chk("lock_entered", int'(bus.busy), 1);
   endtask

   typedef struct {
      int hold;
      int exp_busy;
   } vec_t;

   vec_t vecs[5];

   initial begin
      int target;
      int snap;

      vecs[0] = '{hold: 3,  exp_busy: 3};
      vecs[1] = '{hold: 0,  exp_busy: 1};
      vecs[2] = '{hold: 1,  exp_busy: 1};
      vecs[3] = '{hold: 5,  exp_busy: 5};
      vecs[4] = '{hold: 15, exp_busy: 15};

      bus.job_valid = 1'b0;
      bus.hold_len  = '0;
      repeat (3) tick();
      rst = 1'b0;
      tick();

      // Reset state
      chk("rst_req",       int'(bus.req), 0);
      chk("rst_busy",      int'(bus.busy), 0);
      chk("rst_pending",   int'(bus.pending), 0);
      chk("rst_done",      int'(bus.done), 0);
      chk("rst_overflow",  int'(bus.overflow), 0);
      chk("rst_proto_err", int'(bus.proto_err), 0);

      // Single jobs with assorted hold lengths
      for (int i = 0; i < 5; i++) begin
         bus.hold_len = HOLD_W'(vecs[i].hold);
         chk("idle_req", int'(bus.req), 0);
         target = done_cnt + 1;
         bus.job_valid = 1'b1;
         sb_q.push_back(vecs[i].exp_busy);
         tick();
         bus.job_valid = 1'b0;
         chk("req_latency1", int'(bus.req), 1);
         chk("pending_one", int'(bus.pending), 1);
         wait_done(target, 60);
         tick();
         chk("pending_zero", int'(bus.pending), 0);
         chk("done_single", int'(bus.done), 0);
      end
      $display("vector table: %0d jobs issued, %0d done", 5, done_cnt);

      // Overflow: 9 jobs while REQ is starved of ack
      bus.hold_len = HOLD_W'(2);
      ack_block = 1'b1;
      target = done_cnt + 7;
      for (int i = 0; i < 9; i++) begin
         bus.job_valid = 1'b1;
         if (i < 7) sb_q.push_back(2);
         tick();
      end
      bus.job_valid = 1'b0;
      chk("ovf_pending_sat", int'(bus.pending), 7);
      chk("ovf_sticky",      int'(bus.overflow), 1);
      chk("ovf_req_held",    int'(bus.req), 1);
      chk("ovf_not_busy",    int'(bus.busy), 0);
      ack_block = 1'b0;
      wait_done(target, 300);
      chk("ovf_drained",     int'(bus.pending), 0);
      chk("ovf_still_set",   int'(bus.overflow), 1);
      $display("overflow drain: done_cnt=%0d", done_cnt);

      // job_valid coincident with the granting ack, pending=2
      ack_block = 1'b1;
      target = done_cnt + 3;
      bus.job_valid = 1'b1;
      sb_q.push_back(2);
      sb_q.push_back(2);
      tick();
      tick();
      bus.job_valid = 1'b0;
      chk("same_pre_pending", int'(bus.pending), 2);
      bus.job_valid = 1'b1;
      ack_force = 1'b1;
      sb_q.push_back(2);
      tick();
      bus.job_valid = 1'b0;
      ack_block = 1'b0;
      ack_force = 1'b0;
      chk("same_pending", int'(bus.pending), 2);
      chk("same_lock",    int'(bus.busy), 1);
      wait_done(target, 120);
      chk("same_drained", int'(bus.pending), 0);
      $display("same-cycle grant: done_cnt=%0d", done_cnt);

      // Asynchronous reset during LOCK with pending=4
      ack_block = 1'b1;
      bus.hold_len = HOLD_W'(10);
      bus.job_valid = 1'b1;
      repeat (5) tick();
      bus.job_valid = 1'b0;
      chk("rstmid_pending5", int'(bus.pending), 5);
      ack_block = 1'b0;
      wait_busy(20);
      tick();
      tick();
      chk("rstmid_pending4", int'(bus.pending), 4);
      #2;
      rst = 1'b1;
      #1;
      chk("rstmid_req",     int'(bus.req), 0);
      chk("rstmid_busy",    int'(bus.busy), 0);
      chk("rstmid_pending", int'(bus.pending), 0);
      sb_q.delete();
      repeat (3) tick();
      rst = 1'b0;
      snap = done_cnt;
      repeat (6) tick();
      chk("rstmid_no_done", done_cnt, snap);
      chk("rstmid_idle",    int'(bus.req), 0);
      chk("rstmid_ovf_clr", int'(bus.overflow), 0);
      $display("mid-lock reset: done_cnt=%0d", done_cnt);

      // ack dropped in the middle of LOCK
      bus.hold_len = HOLD_W'(8);
      target = done_cnt + 1;
      bus.job_valid = 1'b1;
      sb_q.push_back(8);
      tick();
      bus.job_valid = 1'b0;
      wait_busy(20);
      tick();
      ack_block = 1'b1;
      tick();
`ifdef LOCK_CLIENT_PROTO_CHECK_EN
      chk("proto_set",    int'(bus.proto_err), 1);
      tick();
      tick();
      chk("proto_sticky", int'(bus.proto_err), 1);
`else
      chk("proto_off",    int'(bus.proto_err), 0);
      tick();
      tick();
      chk("proto_off_hold", int'(bus.proto_err), 0);
`endif
      wait_done(target, 60);
      ack_block = 1'b0;
      chk("final_pending", int'(bus.pending), 0);
      chk("sb_empty", sb_q.size(), 0);
      $display("ack drop in LOCK: done_cnt=%0d", done_cnt);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule

// File: doc/lock_client.md
Name: lock_client

Overview:
- Client-side agent at a leaf of the synchronous tree arbiter. Takes the place of a bare client process and drives one req/ack pair of a level-0 arbiter cell.
- Queues incoming job pulses, requests the shared resource and holds the lock for a programmable number of cycles.
- Releases the lock, then waits for ack to fall before re-arming, so the leaf cell always sees a clean idle cycle.

Parameters:
- HOLD_W, 4, width of hold_len and of the internal hold counter.
- PEND_W, 3, width of the pending-job counter; saturates at 2**PEND_W-1.

Ports:
- clk  in  1  single clock, posedge.
- rst  in  1  reset.
- job_valid  in  1  one-cycle pulse per new job.
- hold_len  in  HOLD_W  lock duration in cycles; 0 is treated as 1.
- ack  in  1  grant from leaf cell (ack1/ack2).
- req  out  1  request to leaf cell (req1/req2).
- busy  out  1  high while in critical section.
- pending  out  PEND_W  queued jobs not yet granted.
- done  out  1  one-cycle pulse per completed job.
- overflow  out  1  sticky; a job was dropped at full.
- proto_err  out  1  sticky protocol violation; see Optional Feature.

Behaviour:
- Interface (already decided): one clock, clk; reset rst is asynchronous and active-high.
- Reset, asynchronous, mid-operation included: state=IDLE, pending=0, hold counter=0, req=0, busy=0, done=0, overflow=0, proto_err=0. An in-flight lock is abandoned; req falls immediately.
- FSM states are IDLE, REQ, LOCK, RELEASE. Outputs are Moore decodes: req = (REQ|LOCK), busy = LOCK.
- IDLE -> REQ when (pending!=0 || job_valid). A job_valid in IDLE with pending=0 gives req=1 in the next cycle (latency 1).
- REQ:
  - Stays in REQ while ack=0.
  - On ack=1: -> LOCK; load counter with max(hold_len,1), sampled in that cycle; decrement pending.
- LOCK: decrement counter each cycle; -> RELEASE on the cycle counter==1. LOCK therefore lasts exactly max(hold_len,1) cycles.
- RELEASE:
  - req=0; stay while ack=1.
  - On ack=0: -> IDLE, and done is registered high for the next cycle.
  - Minimum 1 cycle; the leaf cell drops ack one cycle after req falls, so normal RELEASE is 1 cycle.
  - Re-requesting before ack is low is forbidden.
- Pending counter rules:
  - job_valid and grant in the same cycle: pending unchanged.
  - job_valid at pending = max without grant: job dropped, pending held, overflow set (sticky until rst).
  - Grant with pending=0 only occurs via the same-cycle job_valid path; net result pending=0.
- Back-to-back jobs: RELEASE -> IDLE -> REQ. req stays low for at least 2 cycles between locks.
- ack in REQ is sampled only in REQ. ack seen in IDLE is ignored functionally.

Optional Feature:
- Macro LOCK_CLIENT_PROTO_CHECK_EN.
- When defined, proto_err sets (sticky) on any of:
  - ack=1 in IDLE;
  - ack=0 in LOCK;
  - ack=1 for more than 2 consecutive RELEASE cycles.
- When undefined, proto_err is tied 0 and no checker logic is built. The port is present in both cases.

Decomposition:
- Shared package arb_pkg: enum ClientPhase {IDLE, REQ, LOCK, RELEASE}. The existing CellState and ProcPhase enums move here so cells, clients and benches share them.
- One sub-module, hold_timer: load/decrement counter with a last flag (counter==1), HOLD_W wide.

Test Plan:
- Single job, hold_len=3, bench acks 2 cycles after req rises:
  - req high 1 cycle after job_valid;
  - busy high exactly 3 cycles;
  - bench drops ack 1 cycle after req falls;
  - done pulses once; pending returns to 0.
- hold_len=0 → busy high exactly 1 cycle; then the normal RELEASE/done sequence.
- 9 job_valid pulses while REQ is held without ack, PEND_W=3: pending saturates at 7, overflow=1, remaining jobs retained; acking then yields 7 done pulses.
- job_valid in the same cycle as the granting ack, with pending=2: pending stays 2; LOCK entered.
- Assert rst during LOCK with pending=4: req, busy and pending are 0 immediately (before the next clk edge); no done pulse.
- With LOCK_CLIENT_PROTO_CHECK_EN defined, drop ack mid-LOCK: proto_err=1 on the next cycle and stays 1. Without the macro: proto_err stays 0.
